// File: rtl/intra_block_fetch.sv
// Luma 4x4 block fetcher: raster-walks the frame, reads each block row by row
// and offers the packed block alternately to intra engines 1 and 2.
module intra_block_fetch #(
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [127:0]      blk_data,
  output logic [15:0]       blk_row,
  output logic [15:0]       blk_col,
  output logic              e1_valid,
  input  logic              e1_ready,
  output logic              e2_valid,
  input  logic              e2_ready,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    OFFER,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] WPR = ADDR_W'(FRAME_W / 4);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(3 * (FRAME_W / 4) + 1);
  localparam logic [15:0] LAST_COL = 16'(FRAME_W - 4);
  localparam logic [15:0] LAST_ROW = 16'(FRAME_H - 4);

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic                tgl_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rd_q;
  logic [127:0]        data_q;
  logic [15:0]         row_q;
  logic [15:0]         col_q;
  logic                v1_q;
  logic                v2_q;

  logic                xfer;
  logic                last_col;
  logic [ADDR_W-1:0]   base_d;

  assign xfer     = (v1_q & e1_ready) | (v2_q & e2_ready);
  assign last_col = (col_q == LAST_COL);

  // base_q tracks the word address of the current block's top row
  assign base_d = base_q + (last_col ? ROW_STEP : ADDR_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgl_q   <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            row_q   <= '0;
            col_q   <= '0;
            tgl_q   <= 1'b0;
            base_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (cnt_q != 2'd0)
            data_q <= {data_q[95:0], mem_rdata};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rd_q    <= 1'b0;
            state_q <= WAIT;
          end else begin
            addr_q <= addr_q + WPR;
          end
        end
        WAIT: begin
          data_q  <= {data_q[95:0], mem_rdata};
          v1_q    <= ~tgl_q;
          v2_q    <= tgl_q;
          state_q <= OFFER;
        end
        OFFER: begin
          if (xfer) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            tgl_q <= ~tgl_q;
            if (last_col && row_q == LAST_ROW) begin
              col_q   <= '0;
              state_q <= DONE;
            end else begin
              if (last_col) begin
                col_q <= '0;
                row_q <= row_q + 16'd4;
              end else begin
                col_q <= col_q + 16'd4;
              end
              base_q  <= base_d;
              addr_q  <= base_d;
              rd_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= READ;
            end
          end
        end
        DONE: begin
          if (!enable)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd     = rd_q;
  assign mem_addr   = addr_q;
  assign blk_data   = data_q;
  assign blk_row    = row_q;
  assign blk_col    = col_q;
  assign e1_valid   = v1_q;
  assign e2_valid   = v2_q;
  assign busy       = (state_q == READ) || (state_q == WAIT) ||
                      (state_q == OFFER);
  assign frame_done = (state_q == DONE);

endmodule
